// File: rtl/cpu_rp2a03_apu_wave_channel.sv
// Selectable-waveform (triangle / sawtooth / square) successor of the 2A03 triangle channel.
// Optional feature macro: APU_WAVE_MUTE_HOLD_EN (hold last sample and freeze sequencer when muted or idle).
module cpu_rp2a03_apu_wave_channel #(
    parameter int TIMER_W   = 11,
    parameter int SEQ_LOG2  = 5,
    parameter int LIN_W     = 7,
    parameter int AMP_MUL   = 3,
    parameter int OUT_W     = 6,
    parameter int TIMER_MIN = 2,
    parameter int TIMER_MAX = 2045
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             channel_regs_wr_i,
    input  logic [1:0]       channel_regs_addr_i,
    input  logic [7:0]       channel_regs_wr_data_i,
    input  logic             half_frame_i,
    input  logic             quarter_frame_i,
    input  logic             channel_enabled_i,
    output logic             channel_is_active_o,
    output logic [OUT_W-1:0] channel_output_o
);

    typedef enum logic [1:0] {
        MODE_TRIANGLE = 2'b00,
        MODE_SAWTOOTH = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_RESERVED = 2'b11
    } wave_mode_e;

    localparam int LVL_W = SEQ_LOG2 - 1;
    localparam logic [TIMER_W-1:0] LP_TIMER_MIN = TIMER_W'(TIMER_MIN);
    localparam logic [TIMER_W-1:0] LP_TIMER_MAX = TIMER_W'(TIMER_MAX);

    // Length table shared with the pulse and noise channels.
    function automatic logic [7:0] lenTable(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            5'd0:  val = 8'd10;   5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;   5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;   5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;   5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;  5'd9:  val = 8'd8;
            5'd10: val = 8'd60;   5'd11: val = 8'd10;
            5'd12: val = 8'd14;   5'd13: val = 8'd12;
            5'd14: val = 8'd26;   5'd15: val = 8'd14;
            5'd16: val = 8'd12;   5'd17: val = 8'd16;
            5'd18: val = 8'd24;   5'd19: val = 8'd18;
            5'd20: val = 8'd48;   5'd21: val = 8'd20;
            5'd22: val = 8'd96;   5'd23: val = 8'd22;
            5'd24: val = 8'd192;  5'd25: val = 8'd24;
            5'd26: val = 8'd72;   5'd27: val = 8'd26;
            5'd28: val = 8'd16;   5'd29: val = 8'd28;
            5'd30: val = 8'd32;   default: val = 8'd30;
        endcase
        return val;
    endfunction

    logic                r_ctrl;
    logic [LIN_W-1:0]    r_reload;
    wave_mode_e          r_mode;
    logic [TIMER_W-1:0]  r_period;
    logic [TIMER_W-1:0]  r_timer;
    logic [SEQ_LOG2-1:0] r_seq;
    logic [LIN_W-1:0]    r_linear;
    logic                r_reloadFlag;
    logic [7:0]          r_length;
    logic [OUT_W-1:0]    r_out;

    logic             w_wr0;
    logic             w_wr1;
    logic             w_wr2;
    logic             w_wr3;
    logic             w_countersLive;
    logic             w_muted;
    logic             w_step;
    logic [LVL_W-1:0] w_level;
    logic [OUT_W-1:0] w_sample;

    assign w_wr0 = channel_regs_wr_i && (channel_regs_addr_i == 2'd0);
    assign w_wr1 = channel_regs_wr_i && (channel_regs_addr_i == 2'd1);
    assign w_wr2 = channel_regs_wr_i && (channel_regs_addr_i == 2'd2);
    assign w_wr3 = channel_regs_wr_i && (channel_regs_addr_i == 2'd3);

    assign w_countersLive = (r_linear != '0) && (r_length != 8'd0);
    assign w_muted        = (r_period <= LP_TIMER_MIN) || (r_period >= LP_TIMER_MAX);

`ifdef APU_WAVE_MUTE_HOLD_EN
    assign w_step = (r_timer == '0) && w_countersLive && !w_muted;
`else
    assign w_step = (r_timer == '0) && w_countersLive;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl   <= 1'b0;
            r_reload <= '0;
            r_mode   <= MODE_TRIANGLE;
            r_period <= '0;
        end else begin
            if (w_wr0) begin
                r_ctrl   <= channel_regs_wr_data_i[7];
                r_reload <= channel_regs_wr_data_i[LIN_W-1:0];
            end
            if (w_wr1) begin
                r_mode <= wave_mode_e'(channel_regs_wr_data_i[1:0]);
            end
            if (w_wr2) begin
                r_period[7:0] <= channel_regs_wr_data_i;
            end
            if (w_wr3) begin
                r_period[TIMER_W-1:8] <= channel_regs_wr_data_i[TIMER_W-9:0];
            end
        end
    end

    // A reg3 write always re-arms the reload flag, even when it lands on a quarter frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_linear     <= '0;
            r_reloadFlag <= 1'b0;
        end else begin
            if (quarter_frame_i) begin
                if (r_reloadFlag) begin
                    r_linear <= r_reload;
                end else if (r_linear != '0) begin
                    r_linear <= r_linear - 1'b1;
                end
            end
            if (w_wr3) begin
                r_reloadFlag <= 1'b1;
            end else if (quarter_frame_i && !r_ctrl) begin
                r_reloadFlag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_length <= 8'd0;
        end else if (!channel_enabled_i) begin
            r_length <= 8'd0;
        end else if (w_wr3) begin
            r_length <= lenTable(channel_regs_wr_data_i[7:3]);
        end else if (half_frame_i && !r_ctrl && (r_length != 8'd0)) begin
            r_length <= r_length - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer <= '0;
            r_seq   <= '0;
        end else begin
            if (r_timer == '0) begin
                r_timer <= r_period;
            end else begin
                r_timer <= r_timer - 1'b1;
            end
            if (w_step) begin
                r_seq <= r_seq - 1'b1;
            end
        end
    end

    // Triangle folds the low bits around the midpoint: upper half counts up, lower half counts down.
    always_comb begin
        w_level = '0;
        case (r_mode)
            MODE_SAWTOOTH: w_level = r_seq[SEQ_LOG2-1:1];
            MODE_SQUARE:   w_level = {LVL_W{r_seq[SEQ_LOG2-1]}};
            default:       w_level = r_seq[SEQ_LOG2-1] ? r_seq[LVL_W-1:0] : ~r_seq[LVL_W-1:0];
        endcase
    end

    assign w_sample = OUT_W'(OUT_W'(w_level) * OUT_W'(AMP_MUL));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out <= '0;
        end else begin
`ifdef APU_WAVE_MUTE_HOLD_EN
            if (!w_muted && w_countersLive) begin
                r_out <= w_sample;
            end
`else
            r_out <= w_muted ? '0 : w_sample;
`endif
        end
    end

    assign channel_output_o    = r_out;
    assign channel_is_active_o = (r_length != 8'd0);

endmodule

// File: tb/tb_cpu_rp2a03_apu_wave_channel.sv
// Randomized scoreboard bench for cpu_rp2a03_apu_wave_channel; expected waveform changes are
// queued by the stimulus and consumed by an independent output monitor.
module tb_cpu_rp2a03_apu_wave_channel;

    localparam int SEQ_LOG2 = 5;
    localparam int AMP_MUL  = 3;
    localparam int OUT_W    = 6;
    localparam int SEQ_MASK = (1 << SEQ_LOG2) - 1;
`ifdef APU_WAVE_MUTE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        int value;
        int dur;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic             wr;
    logic [1:0]       addr;
    logic [7:0]       wdata;
    logic             halfFrame;
    logic             quarterFrame;
    logic             enabled;
    logic             active;
    logic [OUT_W-1:0] sampleOut;

    int   checkCount = 0;
    int   failCount  = 0;
    bit   monitorOn  = 1'b0;
    exp_t expQ[$];
    int   pos;
    int   lastExp;
    int   cyc = 0;
    logic [OUT_W-1:0] prevOut = '0;

    cpu_rp2a03_apu_wave_channel #(
        .TIMER_W(11), .SEQ_LOG2(SEQ_LOG2), .LIN_W(7), .AMP_MUL(AMP_MUL),
        .OUT_W(OUT_W), .TIMER_MIN(2), .TIMER_MAX(2045)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rstN),
        .channel_regs_wr_i     (wr),
        .channel_regs_addr_i   (addr),
        .channel_regs_wr_data_i(wdata),
        .half_frame_i          (halfFrame),
        .quarter_frame_i       (quarterFrame),
        .channel_enabled_i     (enabled),
        .channel_is_active_o   (active),
        .channel_output_o      (sampleOut)
    );

    always #5 clk = ~clk;

    // Sample value as the waveform rules describe it: level times multiplier, modulo the output width.
    function automatic int expSample(input int mode, input int s);
        int h;
        int lvl;
        h = 1 << (SEQ_LOG2 - 1);
        case (mode)
            1:       lvl = s / 2;
            2:       lvl = (s >= h) ? h - 1 : 0;
            default: lvl = (s >= h) ? s - h : h - 1 - s;
        endcase
        return (lvl * AMP_MUL) % (1 << OUT_W);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d, input logic hf, input logic qf);
        @(negedge clk);
        wr = 1'b1;
        addr = a;
        wdata = d;
        halfFrame = hf;
        quarterFrame = qf;
        @(negedge clk);
        wr = 1'b0;
        halfFrame = 1'b0;
        quarterFrame = 1'b0;
    endtask

    task automatic pulseFrame(input logic hf, input logic qf);
        @(negedge clk);
        halfFrame = hf;
        quarterFrame = qf;
        @(negedge clk);
        halfFrame = 1'b0;
        quarterFrame = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic setPeriod(input int p);
        logic [10:0] pv;
        pv = p[10:0];
        applyStimulus(2'd2, pv[7:0], 1'b0, 1'b0);
        applyStimulus(2'd3, {5'd0, pv[10:8]}, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic checkMute(input string name, input int p, input bit muted);
        setPeriod(p);
        checkOutput(name, int'(sampleOut), (HOLD || muted) ? 0 : 45);
    endtask

    task automatic pushExp(input int v, input int d);
        exp_t item;
        item.value = v;
        item.dur = d;
        expQ.push_back(item);
    endtask

    // Queue every expected output change of one note, then let the channel run until all are seen.
    task automatic runNote(input int mode, input int per, input int steps);
        int newLvl;
        int prevVal;
        int since;
        int lastIdx;
        int lvl;
        int c;
        bit first;
        logic [7:0] d;
        logic [4:0] idx;
        newLvl = expSample(mode, pos);
        if (newLvl != lastExp) pushExp(newLvl, -1);
        prevVal = newLvl;
        since = 0;
        first = 1'b1;
        lastIdx = 0;
        for (int i = 1; i <= steps; i++) begin
            lvl = expSample(mode, (pos - i) & SEQ_MASK);
            since++;
            if (lvl != prevVal) begin
                pushExp(lvl, first ? -1 : since * (per + 1));
                first = 1'b0;
                since = 0;
                lastIdx = i;
                prevVal = lvl;
            end
        end
        pos = (pos - lastIdx) & SEQ_MASK;
        lastExp = prevVal;

        d = 8'($urandom);
        d[1:0] = mode[1:0];
        applyStimulus(2'd1, d, 1'b0, 1'b0);
        applyStimulus(2'd2, per[7:0], 1'b0, 1'b0);
        enabled = 1'b1;
        idx = 5'($urandom);
        applyStimulus(2'd3, {idx, 3'd0}, 1'b0, 1'b0);
        pulseFrame(1'b0, 1'b1);
        checkOutput("note_active", int'(active), 1);

        c = 0;
        while (expQ.size() != 0 && c < 5000) begin
            @(negedge clk);
            halfFrame = ($urandom_range(0, 15) == 0);
            quarterFrame = ($urandom_range(0, 15) == 0);
            c++;
        end
        enabled = 1'b0;
        halfFrame = 1'b0;
        quarterFrame = 1'b0;
        if (expQ.size() != 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL note_timeout: actual=%0d pending required=0 pending", expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk);
        checkOutput("freeze_active", int'(active), 0);
    endtask

    // Monitor: every output change must match the next queued expectation and its hold time.
    always @(negedge clk) begin
        exp_t item;
        cyc++;
        if (sampleOut !== prevOut) begin
            if (monitorOn) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_change: actual=%0d required=no change", sampleOut);
                end else begin
                    item = expQ.pop_front();
                    checkOutput("wave_value", int'(sampleOut), item.value);
                    if (item.dur >= 0) checkOutput("wave_duration", cyc, item.dur);
                end
            end
            prevOut = sampleOut;
            cyc = 0;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nMode;
        int nPer;
        int nSteps;
        rstN = 1'b0;
        wr = 1'b0;
        addr = 2'd0;
        wdata = 8'd0;
        halfFrame = 1'b0;
        quarterFrame = 1'b0;
        enabled = 1'b0;

        doReset();
        checkOutput("reset_output", int'(sampleOut), 0);
        checkOutput("reset_active", int'(active), 0);

        checkMute("mute_at_min", 2, 1'b1);
        checkMute("unmuted_above_min", 3, 1'b0);
        checkMute("mute_at_max", 2045, 1'b1);
        checkMute("unmuted_below_max", 2044, 1'b0);
        checkMute("mute_period_one", 1, 1'b1);

        enabled = 1'b1;
        applyStimulus(2'd0, 8'h00, 1'b0, 1'b0);
        applyStimulus(2'd3, 8'h08, 1'b0, 1'b0);
        checkOutput("length_loaded", int'(active), 1);
        repeat (253) pulseFrame(1'b1, 1'b0);
        checkOutput("length_253_frames", int'(active), 1);
        pulseFrame(1'b1, 1'b0);
        checkOutput("length_254_frames", int'(active), 0);
        pulseFrame(1'b1, 1'b0);
        checkOutput("length_no_underflow", int'(active), 0);

        applyStimulus(2'd0, 8'h80, 1'b0, 1'b0);
        applyStimulus(2'd3, 8'h08, 1'b0, 1'b0);
        repeat (300) pulseFrame(1'b1, 1'b0);
        checkOutput("length_halted", int'(active), 1);

        enabled = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("disable_clears", int'(active), 0);
        applyStimulus(2'd3, 8'h08, 1'b0, 1'b0);
        checkOutput("disabled_load_ignored", int'(active), 0);

        enabled = 1'b1;
        applyStimulus(2'd0, 8'h00, 1'b0, 1'b0);
        applyStimulus(2'd3, 8'h18, 1'b1, 1'b0);
        checkOutput("coincident_load", int'(active), 1);
        pulseFrame(1'b1, 1'b0);
        checkOutput("coincident_len_1", int'(active), 1);
        pulseFrame(1'b1, 1'b0);
        checkOutput("coincident_len_0", int'(active), 0);

        doReset();
        applyStimulus(2'd0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(2'd2, 8'h10, 1'b0, 1'b0);
        applyStimulus(2'd3, 8'h08, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        checkOutput("linear_coincident_no_reload", int'(sampleOut), HOLD ? 0 : 45);
        pulseFrame(1'b0, 1'b1);
        repeat (60) @(negedge clk);
        checkOutput("linear_reload_steps", int'(sampleOut != 6'd45), 1);

        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_output", int'(sampleOut), 0);
        checkOutput("async_reset_active", int'(active), 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(2'd2, 8'h10, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        checkOutput("post_reset_frozen", int'(sampleOut), HOLD ? 0 : 45);
        checkOutput("post_reset_inactive", int'(active), 0);

        enabled = 1'b0;
        applyStimulus(2'd0, 8'hFF, 1'b0, 1'b0);
        pos = 0;
        lastExp = HOLD ? 0 : 45;
        monitorOn = 1'b1;
        runNote(0, 16, 32);
        for (int n = 0; n < 7; n++) begin
            nMode = int'($urandom_range(0, 3));
            nPer = int'($urandom_range(3, 30));
            nSteps = int'($urandom_range(17, 40));
            runNote(nMode, nPer, nSteps);
        end
        repeat (50) @(negedge clk);
        monitorOn = 1'b0;
        checkOutput("queue_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
